data_mem_responder: RTL

//   Responder end of the pipeline's M-stage data memory interface. Serves word

---
 rtl/data_mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// M-stage data memory responder: word storage, programmable wait states,
// stall back to the hazard unit and error flagging for bad addresses.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [3:0]  WC    = 4'(WAIT_CYCLES);
  localparam logic [29:0] DW    = 30'(DEPTH);
  localparam logic [31:0] BADRD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        weQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;

  logic [31:0] mem [DEPTH];

  logic          idle;
  logic          curWe;
  logic [31:0]   curAddr;
  logic [31:0]   curWdata;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          err;
  logic          commit;

  // With zero wait states the commit edge is the accept edge,
  // so the live request is used before it is latched.
  assign idle     = (state == IDLE);
  assign curWe    = idle ? we_i    : weQ;
  assign curAddr  = idle ? addr_i  : addrQ;
  assign curWdata = idle ? wdata_i : wdataQ;

  assign off = curAddr - BASE_ADDR;
  assign idx = off[AW+1:2];

  // An unaligned BASE_ADDR also misaligns the word offset.
  assign err = (curAddr[1:0] != 2'b00)
             | (off[1:0] != 2'b00)
             | (curAddr < BASE_ADDR)
             | (off[31:2] >= DW);

  assign commit = reset & (
      (idle & req_i & (WC == 4'd0))
    | ((state == WAIT) & (cnt == 4'd1)));

  assign stall_o = req_i & (state != RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      weQ     <= 1'b0;
      addrQ   <= 32'h0;
      wdataQ  <= 32'h0;
      rdata_o <= 32'h0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      if (commit) begin
        ack_o <= 1'b1;
        err_o <= err;
        if (!curWe) begin
          rdata_o <= err ? BADRD : mem[idx];
        end
      end
      unique case (state)
        IDLE: begin
          if (req_i) begin
            weQ    <= we_i;
            addrQ  <= addr_i;
            wdataQ <= wdata_i;
            cnt    <= WC;
            state  <= (WC == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage survives reset; a reset mid-access never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && curWe && !err) begin
      mem[idx] <= curWdata;
    end
  end

endmodule
